// File: rtl/inst_check_pkg.sv
// Shared constants and the decoded-slot record for the instruction check stage.
package inst_check_pkg;

    // Bit positions inside one instruction packet.
    localparam int VALID_BIT   = 65;
    localparam int PRED_BIT    = 16;
    localparam int STR_EN_BIT  = 25;
    localparam int MODE_HI     = 31;
    localparam int MODE_LO     = 30;
    localparam int NO_EXE_HI   = 21;
    localparam int NO_EXE_LO   = 19;

    // Recovery PC carried per slot.
    localparam int PC_W        = 16;

    // One decoded instruction slot.
    typedef struct packed {
        logic            inst_val;
        logic            pr_need;
        logic            str_en;
        logic            spec_brch;
        logic            brch_pred_res;
        logic            no_exe;
        logic            jr;
        logic [1:0]      brch_mode;
        logic [PC_W-1:0] rcvr_pc;
    } decoded_slot_t;

endpackage

// File: rtl/inst_field_decode.sv
// Combinational decode of a single instruction packet into its ROB fields.
module inst_field_decode
    import inst_check_pkg::*;
#(
    parameter int INST_W = 66,
    parameter int JR_BIT = 17
) (
    input  logic [INST_W-1:0] inst_i,
    output decoded_slot_t     dec_o
);

    // Only a handful of packet bits matter here; fold the rest away.
    logic unused_bits;
    assign unused_bits = ^inst_i;

    // Pull each field out of its fixed bit position.
    always_comb begin
        dec_o               = '0;
        dec_o.inst_val      = inst_i[VALID_BIT];
        dec_o.pr_need       = inst_i[PRED_BIT];
        dec_o.brch_pred_res = inst_i[PRED_BIT];
        dec_o.str_en        = inst_i[STR_EN_BIT];
        dec_o.brch_mode     = inst_i[MODE_HI:MODE_LO];
        dec_o.spec_brch     = |inst_i[MODE_HI:MODE_LO];
        dec_o.no_exe        = ~(|inst_i[NO_EXE_HI:NO_EXE_LO]);
        dec_o.jr            = inst_i[JR_BIT];
        dec_o.rcvr_pc       = inst_i[PC_W-1:0];
    end

endmodule

// File: rtl/inst_check_stage.sv
// Decodes instruction groups on acceptance and buffers them in a 2-entry FIFO
// for the ROB. Handshake: a transfer happens on a rising edge where valid and
// ready are both high (and flush is low); ready never depends on valid, and
// in_ready depends only on occupancy, so a full FIFO does not take a group
// even in the cycle it is being drained.
module inst_check_stage
    import inst_check_pkg::*;
#(
    parameter int WIDTH  = 4,
    parameter int INST_W = 66,
    parameter int TAG_W  = 4,
    parameter int JR_BIT = 17
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [WIDTH*INST_W-1:0]      in_inst,
    input  logic                         flush,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [WIDTH-1:0]             inst_val_to_rob,
    output logic [WIDTH-1:0]             pr_need_inst_out,
    output logic [WIDTH-1:0]             str_en_to_rob,
    output logic [WIDTH-1:0]             spec_brch_to_rob,
    output logic [WIDTH-1:0]             brch_pred_res_to_rob,
    output logic [WIDTH-1:0]             no_exe_to_rob,
    output logic [WIDTH-1:0]             jr_to_rob,
    output logic [2*WIDTH-1:0]           brch_mode_to_rob,
    output logic [16*WIDTH-1:0]          rcvr_pc_to_rob,
    output logic [$clog2(WIDTH+1)-1:0]   inst_cnt_out,
    output logic [TAG_W-1:0]             group_tag_out
);

    localparam int CNT_W = $clog2(WIDTH+1);
    localparam int ENT_W = 9*WIDTH + PC_W*WIDTH + CNT_W + TAG_W;

    decoded_slot_t        dec [WIDTH];
    logic [WIDTH-1:0]     n_val, n_pr, n_str, n_spec, n_bpr, n_noexe, n_jr;
    logic [2*WIDTH-1:0]   n_mode;
    logic [PC_W*WIDTH-1:0] n_pc;
    logic [CNT_W-1:0]     n_cnt;
    logic [ENT_W-1:0]     new_ent;
    logic [ENT_W-1:0]     head_ent;

    logic [1:0]           occ_q, occ_d;
    logic [TAG_W-1:0]     tag_q, tag_d;
    logic [ENT_W-1:0]     mem0_q, mem0_d;
    logic [ENT_W-1:0]     mem1_q, mem1_d;

    logic                 accept, push, pop;

    for (genvar g = 0; g < WIDTH; g++) begin : g_dec
        inst_field_decode #(
            .INST_W (INST_W),
            .JR_BIT (JR_BIT)
        ) u_dec (
            .inst_i (in_inst[g*INST_W +: INST_W]),
            .dec_o  (dec[g])
        );
    end

    // Gather per-slot decode results into group vectors and count valid slots.
    always_comb begin
        n_val   = '0;
        n_pr    = '0;
        n_str   = '0;
        n_spec  = '0;
        n_bpr   = '0;
        n_noexe = '0;
        n_jr    = '0;
        n_mode  = '0;
        n_pc    = '0;
        n_cnt   = '0;
        for (int i = 0; i < WIDTH; i++) begin
            n_val[i]              = dec[i].inst_val;
            n_pr[i]               = dec[i].pr_need;
            n_str[i]              = dec[i].str_en;
            n_spec[i]             = dec[i].spec_brch;
            n_bpr[i]              = dec[i].brch_pred_res;
            n_noexe[i]            = dec[i].no_exe;
            n_jr[i]               = dec[i].jr;
            n_mode[2*i +: 2]      = dec[i].brch_mode;
            n_pc[PC_W*i +: PC_W]  = dec[i].rcvr_pc;
            n_cnt                 = n_cnt + CNT_W'(dec[i].inst_val);
        end
    end

    assign new_ent = {n_val, n_pr, n_str, n_spec, n_bpr, n_noexe, n_jr,
                      n_mode, n_pc, n_cnt, tag_q};

    assign in_ready  = rst_n & (occ_q != 2'd2);
    assign out_valid = (occ_q != 2'd0);
    assign accept    = in_valid & in_ready & ~flush;
    // Groups with no valid slot are consumed but never stored.
    assign push      = accept & (|n_val);
    assign pop       = out_valid & out_ready & ~flush;

    // FIFO next state: entry 0 is always the head; a pop shifts entry 1 down.
    always_comb begin
        occ_d  = occ_q;
        tag_d  = tag_q;
        mem0_d = mem0_q;
        mem1_d = mem1_q;
        if (flush) begin
            occ_d = 2'd0;
        end else begin
            if (push) begin
                tag_d = tag_q + TAG_W'(1);
            end
            if (push && pop) begin
                // Only reachable at occupancy 1: the new group replaces the head.
                mem0_d = new_ent;
            end else if (pop) begin
                mem0_d = mem1_q;
                occ_d  = occ_q - 2'd1;
            end else if (push) begin
                if (occ_q == 2'd0) begin
                    mem0_d = new_ent;
                end else begin
                    mem1_d = new_ent;
                end
                occ_d = occ_q + 2'd1;
            end
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ_q  <= 2'd0;
            tag_q  <= '0;
            mem0_q <= '0;
            mem1_q <= '0;
        end else begin
            occ_q  <= occ_d;
            tag_q  <= tag_d;
            mem0_q <= mem0_d;
            mem1_q <= mem1_d;
        end
    end

    assign head_ent = out_valid ? mem0_q : '0;
    assign {inst_val_to_rob, pr_need_inst_out, str_en_to_rob, spec_brch_to_rob,
            brch_pred_res_to_rob, no_exe_to_rob, jr_to_rob, brch_mode_to_rob,
            rcvr_pc_to_rob, inst_cnt_out, group_tag_out} = head_ent;

endmodule

// File: tb/tb_inst_check_stage.sv
// Self-checking bench for inst_check_stage: directed scenarios plus random
// traffic compared against a queue-based model of the stage.
module tb_inst_check_stage;

    localparam int WIDTH  = 4;
    localparam int INST_W = 66;
    localparam int TAG_W  = 4;
    localparam int JR_BIT = 17;
    localparam int CNT_W  = $clog2(WIDTH+1);
    localparam int GW     = WIDTH*INST_W;

    logic               clk;
    logic               rst_n;
    logic               in_valid;
    logic               in_ready;
    logic [GW-1:0]      in_inst;
    logic               flush;
    logic               out_valid;
    logic               out_ready;
    logic [WIDTH-1:0]   inst_val_to_rob, pr_need_inst_out, str_en_to_rob;
    logic [WIDTH-1:0]   spec_brch_to_rob, brch_pred_res_to_rob, no_exe_to_rob, jr_to_rob;
    logic [2*WIDTH-1:0] brch_mode_to_rob;
    logic [16*WIDTH-1:0] rcvr_pc_to_rob;
    logic [CNT_W-1:0]   inst_cnt_out;
    logic [TAG_W-1:0]   group_tag_out;

    inst_check_stage #(
        .WIDTH  (WIDTH),
        .INST_W (INST_W),
        .TAG_W  (TAG_W),
        .JR_BIT (JR_BIT)
    ) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .in_valid             (in_valid),
        .in_ready             (in_ready),
        .in_inst              (in_inst),
        .flush                (flush),
        .out_valid            (out_valid),
        .out_ready            (out_ready),
        .inst_val_to_rob      (inst_val_to_rob),
        .pr_need_inst_out     (pr_need_inst_out),
        .str_en_to_rob        (str_en_to_rob),
        .spec_brch_to_rob     (spec_brch_to_rob),
        .brch_pred_res_to_rob (brch_pred_res_to_rob),
        .no_exe_to_rob        (no_exe_to_rob),
        .jr_to_rob            (jr_to_rob),
        .brch_mode_to_rob     (brch_mode_to_rob),
        .rcvr_pc_to_rob       (rcvr_pc_to_rob),
        .inst_cnt_out         (inst_cnt_out),
        .group_tag_out        (group_tag_out)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_errors = 0;
    logic [GW-1:0]    exp_q[$];
    logic [TAG_W-1:0] exp_tag_q[$];
    int               m_tag = 0;

    task automatic check_eq(input string name, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, obs, exp, $time);
        end
    endtask

    // Compare every output with what the model says the head group should show.
    task automatic check_outputs();
        logic [WIDTH-1:0]    e_val, e_pr, e_str, e_spec, e_noexe, e_jr;
        logic [2*WIDTH-1:0]  e_mode;
        logic [16*WIDTH-1:0] e_pc;
        logic [INST_W-1:0]   p;
        logic [TAG_W-1:0]    e_tag;
        int                  e_cnt;
        e_val = '0; e_pr = '0; e_str = '0; e_spec = '0; e_noexe = '0; e_jr = '0;
        e_mode = '0; e_pc = '0; e_cnt = 0; e_tag = '0;
        if (exp_q.size() > 0) begin
            e_tag = exp_tag_q[0];
            for (int i = 0; i < WIDTH; i++) begin
                p = exp_q[0][i*INST_W +: INST_W];
                e_val[i]        = p[65];
                e_pr[i]         = p[16];
                e_str[i]        = p[25];
                e_mode[2*i +: 2] = p[31:30];
                e_spec[i]       = (p[31:30] != 2'b00);
                e_noexe[i]      = !(p[21] || p[20] || p[19]);
                e_jr[i]         = p[JR_BIT];
                e_pc[16*i +: 16] = p[15:0];
                e_cnt           = e_cnt + int'(p[65]);
            end
        end
        check_eq("in_ready",   in_ready,  exp_q.size() < 2);
        check_eq("out_valid",  out_valid, exp_q.size() > 0);
        check_eq("inst_val",   inst_val_to_rob, e_val);
        check_eq("pr_need",    pr_need_inst_out, e_pr);
        check_eq("str_en",     str_en_to_rob, e_str);
        check_eq("spec_brch",  spec_brch_to_rob, e_spec);
        check_eq("pred_res",   brch_pred_res_to_rob, e_pr);
        check_eq("no_exe",     no_exe_to_rob, e_noexe);
        check_eq("jr",         jr_to_rob, e_jr);
        check_eq("brch_mode",  brch_mode_to_rob, e_mode);
        check_eq("rcvr_pc",    rcvr_pc_to_rob, e_pc);
        check_eq("inst_cnt",   inst_cnt_out, e_cnt);
        check_eq("group_tag",  group_tag_out, e_tag);
    endtask

    // ---------------- driver ----------------
    // Drive one cycle, check outputs mid-cycle, advance the model, return at posedge+1.
    task automatic step(input logic v, input logic [GW-1:0] g, input logic ordy, input logic fl);
        bit acc, pp, any_val;
        in_valid  = v;
        in_inst   = g;
        out_ready = ordy;
        flush     = fl;
        @(negedge clk);
        check_outputs();
        acc = v && (exp_q.size() < 2) && !fl;
        pp  = (exp_q.size() > 0) && ordy && !fl;
        any_val = 0;
        for (int i = 0; i < WIDTH; i++) any_val |= g[i*INST_W + 65];
        if (fl) begin
            exp_q.delete();
            exp_tag_q.delete();
        end else begin
            if (pp) begin
                void'(exp_q.pop_front());
                void'(exp_tag_q.pop_front());
            end
            if (acc && any_val) begin
                exp_q.push_back(g);
                exp_tag_q.push_back(TAG_W'(m_tag));
                m_tag = (m_tag + 1) % (1 << TAG_W);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        in_valid = 0; in_inst = '0; out_ready = 0; flush = 0;
        rst_n = 0;
        exp_q.delete();
        exp_tag_q.delete();
        m_tag = 0;
        @(negedge clk);
        rst_n = 1;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [GW-1:0] rand_group(input int valid_pct);
        logic [GW-1:0] g;
        logic [95:0]   r;
        for (int i = 0; i < WIDTH; i++) begin
            r = {$urandom, $urandom, $urandom};
            r[65] = ($urandom_range(99) < valid_pct);
            g[i*INST_W +: INST_W] = r[INST_W-1:0];
        end
        return g;
    endfunction

    // A group whose slot 0 is valid and carries a recognisable PC; other slots invalid.
    function automatic logic [GW-1:0] one_slot(input logic [1:0] mode, input logic [15:0] pc);
        logic [GW-1:0] g;
        g = '0;
        g[65]    = 1'b1;
        g[31:30] = mode;
        g[15:0]  = pc;
        return g;
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        rst_n = 0; in_valid = 0; in_inst = '0; out_ready = 0; flush = 0;
        #3;
        check_eq("rst_in_ready",  in_ready, 1'b0);
        check_eq("rst_out_valid", out_valid, 1'b0);
        check_eq("rst_pc",        rcvr_pc_to_rob, '0);
        check_eq("rst_tag",       group_tag_out, '0);
        @(negedge clk);
        rst_n = 1;
        #1;
        check_eq("rel_in_ready", in_ready, 1'b1);
        @(posedge clk);
        #1;

        // Single group, one-cycle latency and field decode.
        step(1, one_slot(2'b10, 16'h1234), 1, 0);
        check_eq("t27_valid", out_valid, 1'b1);
        check_eq("t27_spec",  spec_brch_to_rob[0], 1'b1);
        check_eq("t27_mode",  brch_mode_to_rob[1:0], 2'b10);
        check_eq("t27_pc",    rcvr_pc_to_rob[15:0], 16'h1234);
        check_eq("t27_cnt",   inst_cnt_out, 1);
        check_eq("t27_tag",   group_tag_out, 0);
        step(0, '0, 1, 0);

        // All-invalid group is dropped and does not advance the tag.
        step(1, '0, 1, 0);
        check_eq("t29_valid", out_valid, 1'b0);
        step(1, one_slot(2'b01, 16'h00ab), 1, 0);
        check_eq("t29_tag", group_tag_out, 1);
        step(0, '0, 1, 0);

        // Back-pressure: two stored, third refused, then drained in order.
        do_reset();
        step(1, rand_group(100), 0, 0);
        step(1, rand_group(100), 0, 0);
        check_eq("t28_full", in_ready, 1'b0);
        step(1, rand_group(100), 0, 0);
        check_eq("t28_tag0", group_tag_out, 0);
        step(0, '0, 1, 0);
        check_eq("t28_tag1", group_tag_out, 1);
        step(0, '0, 1, 0);
        check_eq("t28_empty", out_valid, 1'b0);

        // Flush at occupancy 2 with an incoming group.
        do_reset();
        step(1, rand_group(100), 0, 0);
        step(1, rand_group(100), 0, 0);
        step(1, rand_group(100), 1, 1);
        check_eq("t31_valid", out_valid, 1'b0);
        check_eq("t31_ready", in_ready, 1'b1);
        step(1, rand_group(100), 0, 0);
        check_eq("t31_tag", group_tag_out, 2);
        step(0, '0, 1, 0);

        // Tag wrap after sixteen stored groups.
        do_reset();
        for (int k = 0; k < 17; k++) step(1, rand_group(100), 1, 0);
        check_eq("t30_tag", group_tag_out, 0);

        // Asynchronous reset mid-cycle with one group held.
        #2;
        rst_n = 0;
        #1;
        check_eq("t32_valid", out_valid, 1'b0);
        check_eq("t32_pc",    rcvr_pc_to_rob, '0);
        check_eq("t32_cnt",   inst_cnt_out, 0);
        check_eq("t32_ready", in_ready, 1'b0);
        exp_q.delete();
        exp_tag_q.delete();
        m_tag = 0;
        in_valid = 0;
        @(negedge clk);
        rst_n = 1;
        #1;
        check_eq("t32_rel_ready", in_ready, 1'b1);
        @(posedge clk);
        #1;

        // Random traffic.
        for (int k = 0; k < 400; k++) begin
            step($urandom_range(99) < 70,
                 rand_group(($urandom_range(9) == 0) ? 0 : 60),
                 $urandom_range(99) < 60,
                 $urandom_range(99) < 5);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/inst_check_stage.md
INST_CHECK_STAGE -- requirements
Module: inst_check_stage

Interface
REQ-001 Parameter WIDTH, default 4: instruction slots per group.
REQ-002 Parameter INST_W, default 66: bits per instruction packet.
REQ-003 Parameter TAG_W, default 4: group tag width.
REQ-004 Parameter JR_BIT, default 17: packet bit flagging a register-indirect jump.
REQ-005 Clock and reset: one clock; reset is asynchronous and active-low.
- clk  in  1  sole clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
REQ-006 Input group ports:
- in_valid  in  1  group present.
- in_ready  out  1  stage accepts the group.
- in_inst  in  WIDTH*INST_W  packets; slot i occupies [i*INST_W +: INST_W].
REQ-007 Control input: flush  in  1  discard all buffered groups.
REQ-008 Output group ports:
- out_valid  out  1  group held for the ROB.
- out_ready  in  1  ROB consumes the group.
REQ-009 Output field ports, all WIDTH wide unless stated:
- inst_val_to_rob, pr_need_inst_out, str_en_to_rob, spec_brch_to_rob, brch_pred_res_to_rob, no_exe_to_rob, jr_to_rob.
- brch_mode_to_rob  out  2*WIDTH.
- rcvr_pc_to_rob  out  16*WIDTH.
- inst_cnt_out  out  $clog2(WIDTH+1)  number of set inst_val bits.
- group_tag_out  out  TAG_W  sequence tag of the held group.

Function
REQ-010 Per-slot decode fields:
- inst_val = bit 65; pr_need = brch_pred_res = bit 16; rcvr_pc = [15:0]; str_en = bit 25.
- brch_mode = [31:30]; spec_brch = (brch_mode != 0); no_exe = ~(bit21 | bit20 | bit19); jr = bit JR_BIT.
REQ-011 Decode is applied at acceptance; decoded fields plus count and tag are stored in a 2-entry FIFO; outputs are driven from the head entry.
REQ-012 Latency: a group accepted at edge N is visible on the outputs after edge N when the FIFO was empty, giving one-cycle latency.
REQ-013 in_ready = (occupancy < 2) and rst_n; it depends only on state, so a full FIFO with out_ready=1 does not accept that cycle.
REQ-014 A group is accepted when in_valid & in_ready & ~flush.
REQ-015 An accepted group with all inst_val bits 0 is dropped: not stored and does not advance the tag.
REQ-016 out_valid = (occupancy > 0); a pop occurs on out_valid & out_ready & ~flush.
REQ-017 Simultaneous push and pop at occupancy 1 keeps occupancy at 1, the new group becomes the head, and the pushed data is never lost.
REQ-018 Field outputs are held stable while out_valid=1 and out_ready=0.
REQ-019 Field outputs and inst_cnt_out are 0 when out_valid=0.
REQ-020 group_tag_out increments by 1 per stored group and wraps from 2^TAG_W-1 to 0.
REQ-021 Flush:
- Occupancy becomes 0 at the next edge.
- in_valid and out_ready are ignored in the flush cycle.
- The tag counter is not reset.

Reset
REQ-022 With rst_n low, all of the following are held at 0: occupancy, tag counter, out_valid, in_ready and every field output.
REQ-023 Reset asserted mid-operation discards buffered groups immediately and asynchronously.
REQ-024 in_ready rises combinationally once rst_n is high.

Structure
REQ-025 Package inst_check_pkg holds the field bit-position constants (valid, pred, str_en, mode, no_exe range), the PC width (16) and a decoded-slot struct typedef.
REQ-026 Sub-module inst_field_decode decodes one packet combinationally and is instantiated WIDTH times; the FIFO is inline.

Verification
REQ-027 Single group with slot0 = {bit65=1, [31:30]=2'b10, [15:0]=16'h1234} and out_ready=1 -> next cycle out_valid=1, spec_brch_to_rob[0]=1, brch_mode_to_rob[1:0]=2'b10, rcvr_pc_to_rob[15:0]=16'h1234, inst_cnt_out=1, group_tag_out=0.
REQ-028 out_ready=0 and three back-to-back groups -> first two stored, in_ready=0 on the third; set out_ready=1 -> tags 0, 1 delivered in order.
REQ-029 Group with all inst_val bits 0 -> no out_valid; the next valid group carries the unadvanced tag.
REQ-030 Seventeen stored groups with TAG_W=4 -> the 17th carries tag 0.
REQ-031 Flush with occupancy 2 and in_valid=1 -> occupancy 0 next cycle, the input group is not stored, the tag is unchanged.
REQ-032 rst_n pulsed low with occupancy 1 -> out_valid=0 and outputs 0 immediately; in_ready=1 after release.
